// File: rtl/core_pkg.sv
// Shared core definitions: PC-select encoding used by both the decoder and fetch,
// and the fetch-stage state encoding.
package core_pkg;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JR     = 2'd2;
    localparam logic [1:0] PC_JUMP   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_ERR  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for sequential, branch, jr and j/jal flow.
module next_pc_calc
    import core_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] ir,
    input  logic [1:0]  pc_control,
    input  logic        branch_taken,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] seq_pc;
    logic [31:0] branch_off;
    logic        unused_ir_hi;

    assign seq_pc       = pc + 32'd4;
    assign branch_off   = {{14{ir[15]}}, ir[15:0], 2'b00};
    assign unused_ir_hi = ^ir[31:26];

    always_comb begin
        next_pc    = seq_pc;
        misaligned = 1'b0;
        case (pc_control)
            PC_SEQ:    next_pc = seq_pc;
            PC_BRANCH: next_pc = branch_taken ? (seq_pc + branch_off) : seq_pc;
            PC_JR: begin
                // Low bits are dropped so fetch keeps going; the fault is only flagged.
                next_pc    = {jr_target[31:2], 2'b00};
                misaligned = (jr_target[1:0] != 2'b00);
            end
            PC_JUMP:   next_pc = {seq_pc[31:28], ir[25:0], 2'b00};
            default:   next_pc = seq_pc;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches over imem request/response, holds IR until
// execute completes, then steps to the decoder-selected next PC.
module instr_fetch
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic [31:0] pc,
    input  logic        ex_done,
    input  logic [1:0]  pc_control,
    input  logic        branch_taken,
    input  logic [31:0] jr_target,
    output logic [31:0] link_addr,
    output logic [31:0] retired,
    output logic        fetch_err,
    output logic        align_err,
    output logic [2:0]  dbg_state
);

    // Handshake: a request is accepted on a rising edge where imem_req and
    // imem_ready are both high; imem_req then holds until that edge. A response is
    // taken on any edge with imem_rvalid high while waiting, and ignored otherwise.

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    fetch_state_t state;
    logic [7:0]   wait_cnt;
    logic [31:0]  next_pc;
    logic         misaligned;

    next_pc_calc u_next_pc (
        .pc           (pc),
        .ir           (ir),
        .pc_control   (pc_control),
        .branch_taken (branch_taken),
        .jr_target    (jr_target),
        .next_pc      (next_pc),
        .misaligned   (misaligned)
    );

    assign imem_addr = pc;
    assign link_addr = pc + 32'd4;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            ir        <= 32'd0;
            ir_valid  <= 1'b0;
            imem_req  <= 1'b0;
            retired   <= 32'd0;
            fetch_err <= 1'b0;
            align_err <= 1'b0;
            wait_cnt  <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state    <= ST_REQ;
                        imem_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (imem_ready) begin
                        state    <= ST_WAIT;
                        imem_req <= 1'b0;
                        wait_cnt <= 8'd0;
                    end
                end
                ST_WAIT: begin
                    // A response on the final counted cycle still wins over the timeout.
                    if (imem_rvalid) begin
                        ir       <= imem_rdata;
                        ir_valid <= 1'b1;
                        state    <= ST_HOLD;
                    end else if (wait_cnt == CNT_LAST) begin
                        fetch_err <= 1'b1;
                        state     <= ST_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (ex_done) begin
                        ir_valid <= 1'b0;
                        retired  <= retired + 32'd1;
                        pc       <= next_pc;
                        if (misaligned) begin
                            align_err <= 1'b1;
                        end
                        if (run) begin
                            state    <= ST_REQ;
                            imem_req <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_ERR: begin
                    imem_req <= 1'b0;
                    ir_valid <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Upstream fetch stage for the single-issue MIPS-subset core: owns the PC, reads instruction memory over a request/response handshake, and holds the fetched word in IR for the control decoder.
- Once the instruction completes, it takes the decoder's 2-bit PC-select code plus the execute-stage resolution and computes the next PC.
- Also produces the jal link address and a retired-instruction count.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- TIMEOUT, 16, maximum cycles from request acceptance to response before fetch error; range 2..255.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  fetch enable; a new request starts only while high.
- imem_req  out  1  instruction read request.
- imem_addr  out  32  byte address of request; equals pc.
- imem_ready  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- ir  out  32  current instruction, to decoder.
- ir_valid  out  1  ir holds an unexecuted instruction.
- pc  out  32  address of ir.
- ex_done  in  1  execute finished current instruction; sampled only while ir_valid.
- pc_control  in  2  decoder select: 0 sequential, 1 branch, 2 jr, 3 j/jal.
- branch_taken  in  1  ALU branch outcome; used only when pc_control=1.
- jr_target  in  32  rs value for jr.
- link_addr  out  32  pc+4 of current instruction, for $31 on jal.
- retired  out  32  count of completed instructions.
- fetch_err  out  1  sticky: response timeout.
- align_err  out  1  sticky: jr target with nonzero [1:0].

Behaviour:
- Reset (async, rst_n low):
  - pc=RESET_PC, ir=0, ir_valid=0, imem_req=0, link_addr=RESET_PC+4, retired=0, both error flags=0, state=IDLE.
- FSM states: IDLE, REQ, WAIT, HOLD, ERR.
- IDLE: imem_req=0. If run=1, go to REQ next cycle.
- REQ:
  - imem_req=1 with imem_addr=pc held stable.
  - imem_ready=1 → WAIT and clear the timeout counter.
  - run dropping does not withdraw a pending request.
- WAIT:
  - imem_req=0; counter increments each cycle.
  - imem_rvalid=1 → ir<=imem_rdata, ir_valid<=1, → HOLD.
  - If the counter reaches TIMEOUT without rvalid → fetch_err<=1, → ERR.
  - rvalid on the same cycle the counter hits TIMEOUT counts as success.
  - rvalid in any other state is ignored.
  - Minimum request-to-ir_valid latency: 2 cycles (ready in cycle n, rvalid in n+1, ir_valid visible n+2).
- HOLD:
  - ir and pc stable; link_addr=pc+4 (modulo 2^32).
  - On ex_done=1: ir_valid<=0, retired<=retired+1 (wraps at 2^32), pc<=next_pc.
  - Then → REQ if run=1, else IDLE.
- next_pc, with s = pc+4:
  - 0: s.
  - 1: branch_taken ? s + (sign_extend(ir[15:0])<<2) : s.
  - 2: {jr_target[31:2],2'b00}; set align_err if jr_target[1:0]≠0. Execution continues.
  - 3: {s[31:28], ir[25:0], 2'b00}.
  - All additions wrap modulo 2^32.
- ERR: terminal until reset. imem_req=0, ir_valid=0, pc frozen.
- Reset mid-transaction: returns to IDLE immediately. Any late rvalid after reset is ignored (state≠WAIT).

Decomposition:
- Shared package core_pkg:
  - PC_SEQ=0, PC_BRANCH=1, PC_JR=2, PC_JUMP=3.
  - Fetch state enum.
  - Shared with the decoder so the PC-select encoding has one definition.
- One sub-module: next_pc_calc. Purely combinational; inputs pc, ir, pc_control, branch_taken, jr_target; outputs next_pc, misaligned.

Test Plan:
- Reset then run=1, memory ready immediately, rvalid one cycle later with 0x2008_0005 → imem_addr=0, ir=0x2008_0005 and ir_valid high 2 cycles after ready; ex_done with pc_control=0 → next imem_addr=0x4, retired=1.
- At pc=0x100, ir=beq with imm=0xFFFE, pc_control=1, branch_taken=1 → next pc=0xFC. Same case with branch_taken=0 → pc=0x104.
- At pc=0x4000_0010, ir=0x0C00_0040 (jal), pc_control=3 → link_addr=0x4000_0014, next pc=0x4000_0100.
- jr with jr_target=0x0000_0203 → next pc=0x200, align_err=1 and stays set; fetching continues.
- TIMEOUT=16, ready given, no rvalid for 16 cycles → fetch_err=1, imem_req stays 0 forever. Second run with rvalid on the 16th cycle → normal fetch, fetch_err=0.
- rst_n low during WAIT, then rvalid arrives after release → ir stays 0, ir_valid=0; refetch starts at RESET_PC once run=1.
